// File: rtl/fltadd_batch_seq.sv
// Batch sequencer: walks fixed-layout 6-byte records in data memory, hands each
// same-sign operand pair to the half-precision adder and writes the sum back.
module fltadd_batch_seq #(
   parameter int BASE_ADDR = 128,
   parameter int REC_BYTES = 6,
   parameter int TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  num_pairs,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  skip_cnt,
   output logic [7:0]  mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        add_start,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   input  logic        add_done,
   input  logic [15:0] add_sum
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, RD_AH, RD_AL, RD_BH, RD_BL, CHECK, ISSUE, WAIT, WR_H, WR_L, NEXT, DONE
   } state_t;

   state_t        state, state_nx;
   logic [3:0]    npairs;
   logic [3:0]    rec;
   logic [4:0]    rec_inc;
   logic [7:0]    base;
   logic [15:0]   a_reg, b_reg, r_reg;
   logic [TW-1:0] tcnt;
   logic          tmo;

   // Record base address wraps modulo 256; rec compare uses a 5-bit increment.
   assign base    = 8'(BASE_ADDR + REC_BYTES * int'(rec));
   assign rec_inc = {1'b0, rec} + 5'd1;
   assign tmo     = (tcnt == TW'(TIMEOUT - 1));
   assign add_a   = a_reg;
   assign add_b   = b_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state and memory/adder strobes; strobes are suppressed while reset is high
   // so a write in flight at the reset edge never lands.
   always_comb begin
      state_nx  = state;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 8'd0;
      mem_wdata = 8'd0;
      add_start = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = (num_pairs == 4'd0) ? NEXT : RD_AH;
         RD_AH: begin mem_rd = !reset; mem_addr = base;        state_nx = RD_AL; end
         RD_AL: begin mem_rd = !reset; mem_addr = base + 8'd1; state_nx = RD_BH; end
         RD_BH: begin mem_rd = !reset; mem_addr = base + 8'd2; state_nx = RD_BL; end
         RD_BL: begin mem_rd = !reset; mem_addr = base + 8'd3; state_nx = CHECK; end
         CHECK: state_nx = (a_reg[15] != b_reg[15]) ? WR_H : ISSUE;
         ISSUE: begin add_start = !reset; state_nx = WAIT; end
         WAIT: begin
            if (add_done) state_nx = WR_H;
            else if (tmo) state_nx = DONE;
         end
         WR_H: begin
            mem_wr = !reset; mem_addr = base + 8'd4; mem_wdata = r_reg[15:8]; state_nx = WR_L;
         end
         WR_L: begin
            mem_wr = !reset; mem_addr = base + 8'd5; mem_wdata = r_reg[7:0];  state_nx = NEXT;
         end
         NEXT:  state_nx = (npairs == 4'd0 || rec_inc == {1'b0, npairs}) ? DONE : RD_AH;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand/result capture, record counter, timeout counter and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         npairs   <= 4'd0;
         rec      <= 4'd0;
         a_reg    <= 16'd0;
         b_reg    <= 16'd0;
         r_reg    <= 16'd0;
         tcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         skip_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               npairs   <= num_pairs;
               rec      <= 4'd0;
               done     <= 1'b0;
               err      <= 1'b0;
               skip_cnt <= 4'd0;
               busy     <= 1'b1;
            end
            RD_AH: a_reg[15:8] <= mem_rdata;
            RD_AL: a_reg[7:0]  <= mem_rdata;
            RD_BH: b_reg[15:8] <= mem_rdata;
            RD_BL: b_reg[7:0]  <= mem_rdata;
            CHECK: if (a_reg[15] != b_reg[15]) begin
               r_reg    <= 16'hFFFF;
               skip_cnt <= skip_cnt + 4'd1;
            end
            ISSUE: tcnt <= '0;
            WAIT: begin
               if (add_done) r_reg <= add_sum;
               else if (tmo) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
                  done <= 1'b1;
               end else tcnt <= tcnt + 1'b1;
            end
            NEXT: begin
               rec <= rec_inc[3:0];
               if (state_nx == DONE) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
